alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32, datapath width.
REQ-002 SHALL have parameter NUM_TAGS, default 64, rename tag count; NUM_TAGS_LOG2 = clog2(NUM_TAGS).
REQ-003 SHALL have parameter ROB_SIZE, default 64, ROB entries; ROB_SIZE_LOG2 = clog2(ROB_SIZE).
REQ-004 SHALL have parameter PIPE_DEPTH, default 2, register stages, legal range 1..8.
REQ-005 Ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 Ports: op  in  4  {funct7[5],funct3}; rs1  in  REG_SIZE  operand A; rs2  in  REG_SIZE  operand B or immediate.
REQ-007 Ports: tag_in  in  NUM_TAGS_LOG2  rd tag; rob_index_in  in  ROB_SIZE_LOG2  ROB index; valid_in  in  1  issue valid; ready_out  out  1  unit can accept.
REQ-008 Ports: flush  in  1  squash all in-flight ops.
REQ-009 Ports: rd  out  REG_SIZE  result; tag_out  out  NUM_TAGS_LOG2; rob_index_out  out  ROB_SIZE_LOG2; valid_out  out  1  result valid; ready_in  in  1  CDB accepts result.

Function
REQ-010 Op encoding SHALL be: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-011 Any other op SHALL produce result 0, still retire with valid_out, tag and ROB index.
REQ-012 Shift amount SHALL be rs2[clog2(REG_SIZE)-1:0]; upper rs2 bits ignored.
REQ-013 SRL SHALL zero-fill; SRA SHALL sign-fill from rs1[REG_SIZE-1].
REQ-014 SLT signed, SLTU unsigned compare; result 1 or 0, zero-extended to REG_SIZE.
REQ-015 ADD/SUB SHALL wrap modulo 2^REG_SIZE; no overflow flag.
REQ-016 Result SHALL be computed combinationally and captured with tag/ROB index into stage 0 on accept (valid_in && ready_out && !flush).
REQ-017 Each stage SHALL hold {valid, result, tag, rob_index}; outputs driven from last stage PIPE_DEPTH-1.
REQ-018 Unstalled latency SHALL be exactly PIPE_DEPTH cycles from accept edge to valid_out high.
REQ-019 Result handshake: entry retires on clock where valid_out && ready_in; outputs SHALL hold stable while valid_out && !ready_in.
REQ-020 Stage k SHALL advance when stage k+1 is empty or advancing (bubble collapse); last stage advances when empty or ready_in.
REQ-021 ready_out SHALL equal (stage 0 empty || stage 0 advancing), combinational, independent of valid_in.
REQ-022 Throughput SHALL be one op per cycle with ready_in held high.
REQ-023 Full: all stages valid and ready_in low -> ready_out low; no entry overwritten or lost.
REQ-024 flush SHALL clear every stage valid bit on that edge; op presented in flush cycle SHALL be dropped; valid_out low next cycle.
REQ-025 flush and ready_in high same cycle: retiring entry counts as delivered; consumer SHALL treat flush as overriding.
REQ-026 valid_in low SHALL leave data registers free to hold old values; only valid bits matter.

Reset
REQ-027 On rst all stage valid bits SHALL be 0; rd, tag_out, rob_index_out SHALL be 0.
REQ-028 rst SHALL take priority over flush and accept; in-flight ops discarded mid-operation.
REQ-029 ready_out SHALL be 1 the first cycle after rst deasserts.

Structure
REQ-030 Package alu_pkg SHALL hold op enum alu_op_e and default REG_SIZE/NUM_TAGS/ROB_SIZE constants.
REQ-031 Combinational datapath SHALL be sub-module alu_comb (op, rs1, rs2 -> result); alu_pipe owns pipeline and handshake.
REQ-032 Pipeline SHALL be a generate loop over PIPE_DEPTH; no per-depth hand coding.

Verification
REQ-033 PIPE_DEPTH=2, ready_in=1: ADD 5+7 tag 3 rob 9 at cycle 0 -> rd=12, tag_out=3, rob_index_out=9, valid_out high at cycle 2 only.
REQ-034 SRA rs1=0x80000000 rs2=0x21 -> 0xC0000000; SRL same -> 0x40000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-035 Back-to-back 8 ops, ready_in=0 cycles 3..6 -> ready_out low once 2 stages full, all 8 results delivered in order, none duplicated.
REQ-036 Two ops in flight, flush pulse -> valid_out low next cycle, no result for either; op accepted cycle after flush delivered normally.
REQ-037 rst asserted with 2 ops in flight and ready_in=0 -> all outputs 0, valid_out 0, ready_out 1 after release.
REQ-038 Op 1111 rs1=3 rs2=4 -> rd=0 with valid_out high after PIPE_DEPTH cycles; repeat suite with PIPE_DEPTH=1 and 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU execution unit: op encodings and
// default sizing of the datapath, rename tags and reorder buffer.
package alu_pkg;

   localparam int DEF_REG_SIZE = 32;
   localparam int DEF_NUM_TAGS = 64;
   localparam int DEF_ROB_SIZE = 64;

   // Op code is {funct7[5], funct3} of the RISC-V OP/OP-IMM encodings.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational integer ALU. Unknown op codes yield a zero result so
// the instruction still retires cleanly through the pipeline.
module alu_comb
   import alu_pkg::*;
#(
   parameter int REG_SIZE = DEF_REG_SIZE
) (
   input  logic [3:0]          op,
   input  logic [REG_SIZE-1:0] rs1,
   input  logic [REG_SIZE-1:0] rs2,
   output logic [REG_SIZE-1:0] result
);

   localparam int SHAMT_W = $clog2(REG_SIZE);

   logic [SHAMT_W-1:0]         shamt;
   logic signed [REG_SIZE-1:0] rs1_s;
   logic signed [REG_SIZE-1:0] rs2_s;
   logic signed [REG_SIZE-1:0] sra_s;

   // Only the low log2(REG_SIZE) bits of rs2 select the shift distance.
   assign shamt = rs2[SHAMT_W-1:0];
   assign rs1_s = rs1;
   assign rs2_s = rs2;
   assign sra_s = rs1_s >>> shamt;

   // Decode the op and select the matching arithmetic/logic result
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = rs1 + rs2;
         ALU_SUB:  result = rs1 - rs2;
         ALU_SLL:  result = rs1 << shamt;
         ALU_SLT:  result = {{(REG_SIZE-1){1'b0}}, (rs1_s < rs2_s)};
         ALU_SLTU: result = {{(REG_SIZE-1){1'b0}}, (rs1 < rs2)};
         ALU_XOR:  result = rs1 ^ rs2;
         ALU_SRL:  result = rs1 >> shamt;
         ALU_SRA:  result = sra_s;
         ALU_OR:   result = rs1 | rs2;
         ALU_AND:  result = rs1 & rs2;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU execution unit. The result is computed at issue and then
// carried with its rename tag and ROB index through PIPE_DEPTH elastic
// stages; empty stages collapse so bubbles never throttle throughput, and a
// stalled result bus back-pressures issue through ready_out.
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int REG_SIZE      = DEF_REG_SIZE,
   parameter  int NUM_TAGS      = DEF_NUM_TAGS,
   parameter  int ROB_SIZE      = DEF_ROB_SIZE,
   parameter  int PIPE_DEPTH    = 2,
   localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
   localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               op,
   input  logic [REG_SIZE-1:0]      rs1,
   input  logic [REG_SIZE-1:0]      rs2,
   input  logic [NUM_TAGS_LOG2-1:0] tag_in,
   input  logic [ROB_SIZE_LOG2-1:0] rob_index_in,
   input  logic                     valid_in,
   output logic                     ready_out,
   input  logic                     flush,
   output logic [REG_SIZE-1:0]      rd,
   output logic [NUM_TAGS_LOG2-1:0] tag_out,
   output logic [ROB_SIZE_LOG2-1:0] rob_index_out,
   output logic                     valid_out,
   input  logic                     ready_in
);

   logic [REG_SIZE-1:0]      result;
   logic                     accept;
   logic [PIPE_DEPTH-1:0]    vld_p;
   logic [PIPE_DEPTH-1:0]    adv;
   logic [REG_SIZE-1:0]      res_p [PIPE_DEPTH];
   logic [NUM_TAGS_LOG2-1:0] tag_p [PIPE_DEPTH];
   logic [ROB_SIZE_LOG2-1:0] rob_p [PIPE_DEPTH];

   alu_comb #(
      .REG_SIZE (REG_SIZE)
   ) u_alu_comb (
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .result (result)
   );

   // A stage may move forward when it is empty or its successor is moving;
   // evaluated from the output end back so the chain has a single driver.
   always_comb begin
      adv = '0;
      adv[PIPE_DEPTH-1] = !vld_p[PIPE_DEPTH-1] || ready_in;
      for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
         adv[k] = !vld_p[k] || adv[k+1];
      end
   end

   // ready_out deliberately ignores valid_in and flush so issue logic never
   // sees a combinational loop through this unit.
   assign ready_out = adv[0];
   assign accept    = valid_in && ready_out && !flush;

   for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         // Stage 0: capture the freshly computed result on an accepted issue
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p[0] <= 1'b0;
               res_p[0] <= '0;
               tag_p[0] <= '0;
               rob_p[0] <= '0;
            end else if (flush) begin
               vld_p[0] <= 1'b0;
            end else if (adv[0]) begin
               vld_p[0] <= accept;
               if (accept) begin
                  res_p[0] <= result;
                  tag_p[0] <= tag_in;
                  rob_p[0] <= rob_index_in;
               end
            end
         end
      end else begin : g_body
         // Stage k: take over the predecessor's entry whenever this stage moves
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_p[k] <= 1'b0;
               res_p[k] <= '0;
               tag_p[k] <= '0;
               rob_p[k] <= '0;
            end else if (flush) begin
               vld_p[k] <= 1'b0;
            end else if (adv[k]) begin
               vld_p[k] <= vld_p[k-1];
               if (vld_p[k-1]) begin
                  res_p[k] <= res_p[k-1];
                  tag_p[k] <= tag_p[k-1];
                  rob_p[k] <= rob_p[k-1];
               end
            end
         end
      end
   end

   assign valid_out     = vld_p[PIPE_DEPTH-1];
   assign rd            = res_p[PIPE_DEPTH-1];
   assign tag_out       = tag_p[PIPE_DEPTH-1];
   assign rob_index_out = rob_p[PIPE_DEPTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: three instances (PIPE_DEPTH 1, 2, 4) are
// exercised one after another with the same directed suite. Issue pushes the
// hand-computed expectation; a negedge monitor pops on every retirement.
module tb_alu_pipe;

   localparam int ND = 3;
   localparam int RS = 32;
   localparam int TW = 6;
   localparam int RW = 6;

   typedef struct {
      logic [RS-1:0] res;
      logic [TW-1:0] tg;
      logic [RW-1:0] rb;
   } exp_t;

   typedef struct {
      logic [3:0]    o;
      logic [RS-1:0] a;
      logic [RS-1:0] b;
      logic [RS-1:0] r;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    op      [ND];
   logic [RS-1:0] rs1     [ND];
   logic [RS-1:0] rs2     [ND];
   logic [TW-1:0] tag_in  [ND];
   logic [RW-1:0] rob_in  [ND];
   logic          vin     [ND];
   logic          rdy_out [ND];
   logic          flush   [ND];
   logic [RS-1:0] rd      [ND];
   logic [TW-1:0] tag_out [ND];
   logic [RW-1:0] rob_out [ND];
   logic          vout    [ND];
   logic          rdy_in  [ND];

   exp_t exp_q [ND][$];
   int   n_done [ND];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   vec_t vecs [17];

   logic          hold_v   [ND];
   logic [RS-1:0] hold_rd  [ND];
   logic [TW-1:0] hold_tag [ND];
   logic [RW-1:0] hold_rob [ND];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      alu_pipe #(
         .REG_SIZE   (RS),
         .NUM_TAGS   (64),
         .ROB_SIZE   (64),
         .PIPE_DEPTH (1 << g)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .op            (op[g]),
         .rs1           (rs1[g]),
         .rs2           (rs2[g]),
         .tag_in        (tag_in[g]),
         .rob_index_in  (rob_in[g]),
         .valid_in      (vin[g]),
         .ready_out     (rdy_out[g]),
         .flush         (flush[g]),
         .rd            (rd[g]),
         .tag_out       (tag_out[g]),
         .rob_index_out (rob_out[g]),
         .valid_out     (vout[g]),
         .ready_in      (rdy_in[g])
      );
   end

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h required %h", name, d, act, req);
      end
   endtask

   // Monitor: compare every retirement against the scoreboard and check that
   // a stalled output holds steady until it is taken.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         if (rst) begin
            hold_v[d] = 1'b0;
         end else begin
            if (hold_v[d]) begin
               chk("hold_valid", d, {31'b0, vout[d]}, 32'd1);
               chk("hold_rd", d, rd[d], hold_rd[d]);
               chk("hold_tag", d, {26'b0, tag_out[d]}, {26'b0, hold_tag[d]});
               chk("hold_rob", d, {26'b0, rob_out[d]}, {26'b0, hold_rob[d]});
            end
            hold_v[d] = 1'b0;
            if (vout[d] && rdy_in[d]) begin
               if (exp_q[d].size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_result dut%0d: got rd=%h tag=%0d rob=%0d, required no result",
                           d, rd[d], tag_out[d], rob_out[d]);
               end else begin
                  e = exp_q[d].pop_front();
                  chk("rd", d, rd[d], e.res);
                  chk("tag_out", d, {26'b0, tag_out[d]}, {26'b0, e.tg});
                  chk("rob_index_out", d, {26'b0, rob_out[d]}, {26'b0, e.rb});
                  n_done[d]++;
               end
            end else if (vout[d] && !flush[d]) begin
               hold_v[d]   = 1'b1;
               hold_rd[d]  = rd[d];
               hold_tag[d] = tag_out[d];
               hold_rob[d] = rob_out[d];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int d, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input logic [5:0] r, input logic [31:0] er);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      op[d] = o; rs1[d] = a; rs2[d] = b; tag_in[d] = t; rob_in[d] = r; vin[d] = 1'b1;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = rdy_out[d];
         if (acc) exp_q[d].push_back('{res: er, tg: t, rb: r});
         tick();
         n++;
      end
      vin[d] = 1'b0;
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout dut%0d: ready_out 0 for %0d cycles, required 1", d, n);
      end
   endtask

   // Called right after the accept edge: valid_out must rise exactly once,
   // PIPE_DEPTH cycles after accept, with ready_in high.
   task automatic lat_check(input int d, input int depth);
      for (int k = 1; k <= depth + 1; k++) begin
         @(negedge clk);
         chk("latency_valid", d, {31'b0, vout[d]}, {31'b0, (k == depth)});
         tick();
      end
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (exp_q[d].size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_left", d, exp_q[d].size(), 32'd0);
      repeat (2) tick();
   endtask

   task automatic run_suite(input int d);
      int   depth;
      int   nf;
      int   c0;
      int   done0;
      logic saw_full;
      depth = 1 << d;
      nf    = (depth >= 2) ? 2 : 1;

      // First-result latency and undefined-op retirement
      rdy_in[d] = 1'b1;
      issue(d, 4'b0000, 32'd5, 32'd7, 6'd3, 6'd9, 32'd12);
      lat_check(d, depth);
      issue(d, 4'b1111, 32'd3, 32'd4, 6'd5, 6'd6, 32'd0);
      lat_check(d, depth);

      // Directed op vectors, back-to-back: one accept per cycle
      c0 = cyc;
      for (int i = 0; i < 17; i++)
         issue(d, vecs[i].o, vecs[i].a, vecs[i].b, 6'(i), 6'(63 - i), vecs[i].r);
      chk("throughput_cycles", d, cyc - c0, 32'd17);
      drain(d);

      // Eight ops with the result bus stalled in cycles 3..6
      saw_full = 1'b0;
      done0    = n_done[d];
      fork
         begin
            for (int i = 0; i < 8; i++)
               issue(d, 4'b0000, 32'(i), 32'd100, 6'(10 + i), 6'(20 + i), 32'(100 + i));
         end
         begin
            repeat (3) tick();
            rdy_in[d] = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (!rdy_out[d]) saw_full = 1'b1;
               tick();
            end
            rdy_in[d] = 1'b1;
         end
      join
      chk("stall_ready_low", d, {31'b0, saw_full}, 32'd1);
      drain(d);
      chk("stall_delivered", d, n_done[d] - done0, 32'd8);

      // Flush with ops in flight, then an op issued the very next cycle
      rdy_in[d] = 1'b0;
      for (int i = 0; i < nf; i++)
         issue(d, 4'b0100, 32'hFF, 32'(i), 6'(30 + i), 6'(40 + i), 32'(32'hFF ^ i));
      op[d] = 4'b0000; rs1[d] = 32'd1; rs2[d] = 32'd1; vin[d] = 1'b1; flush[d] = 1'b1;
      tick();
      flush[d] = 1'b0;
      exp_q[d].delete();
      rdy_in[d] = 1'b1;
      op[d] = 4'b1000; rs1[d] = 32'd50; rs2[d] = 32'd8; tag_in[d] = 6'd1; rob_in[d] = 6'd2;
      @(negedge clk);
      chk("flush_valid_low", d, {31'b0, vout[d]}, 32'd0);
      chk("flush_ready", d, {31'b0, rdy_out[d]}, 32'd1);
      exp_q[d].push_back('{res: 32'd42, tg: 6'd1, rb: 6'd2});
      tick();
      vin[d] = 1'b0;
      lat_check(d, depth);
      drain(d);

      // Reset with ops in flight and the result bus stalled
      rdy_in[d] = 1'b0;
      for (int i = 0; i < nf; i++)
         issue(d, 4'b0110, 32'h0F00, 32'(i + 1), 6'(50 + i), 6'(60 + i), 32'(32'h0F00 | (i + 1)));
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_valid", d, {31'b0, vout[d]}, 32'd0);
      chk("rst_rd", d, rd[d], 32'd0);
      chk("rst_tag", d, {26'b0, tag_out[d]}, 32'd0);
      chk("rst_rob", d, {26'b0, rob_out[d]}, 32'd0);
      tick();
      rst = 1'b0;
      exp_q[d].delete();
      @(negedge clk);
      chk("post_rst_ready", d, {31'b0, rdy_out[d]}, 32'd1);
      chk("post_rst_valid", d, {31'b0, vout[d]}, 32'd0);
      tick();
      rdy_in[d] = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'b1101, 32'h80000000, 32'h00000021, 32'hC0000000};
      vecs[1]  = '{4'b0101, 32'h80000000, 32'h00000021, 32'h40000000};
      vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
      vecs[3]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[4]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
      vecs[5]  = '{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
      vecs[6]  = '{4'b0001, 32'h00000001, 32'h00000024, 32'h00000010};
      vecs[7]  = '{4'b1101, 32'hF0000000, 32'h0000001F, 32'hFFFFFFFF};
      vecs[8]  = '{4'b0101, 32'hF0000000, 32'h0000001C, 32'h0000000F};
      vecs[9]  = '{4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
      vecs[10] = '{4'b0110, 32'h12340000, 32'h00005678, 32'h12345678};
      vecs[11] = '{4'b0111, 32'h12345678, 32'h0F0F0F0F, 32'h02040608};
      vecs[12] = '{4'b1001, 32'h00000003, 32'h00000004, 32'h00000000};
      vecs[13] = '{4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
      vecs[14] = '{4'b0011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
      vecs[15] = '{4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
      vecs[16] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};

      rst = 1'b1;
      for (int d = 0; d < ND; d++) begin
         op[d] = '0; rs1[d] = '0; rs2[d] = '0; tag_in[d] = '0; rob_in[d] = '0;
         vin[d] = 1'b0; flush[d] = 1'b0; rdy_in[d] = 1'b1; n_done[d] = 0;
      end
      repeat (3) tick();
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("reset_valid", d, {31'b0, vout[d]}, 32'd0);
         chk("reset_rd", d, rd[d], 32'd0);
         chk("reset_tag", d, {26'b0, tag_out[d]}, 32'd0);
         chk("reset_rob", d, {26'b0, rob_out[d]}, 32'd0);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < ND; d++)
         chk("reset_release_ready", d, {31'b0, rdy_out[d]}, 32'd1);
      tick();

      for (int d = 0; d < ND; d++) run_suite(d);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
